// File: rtl/booth_pkg.sv
// Shared constants and FSM state type for the Booth multiplier datapath.
// The accumulator and the multiplier stage both size themselves from here.
package booth_pkg;

  localparam int N       = 10;
  localparam int ACC_LEN = 8;
  localparam int PW      = 2 * N;
  localparam int ACC_W   = PW + $clog2(ACC_LEN);
  localparam int CW      = $clog2(ACC_LEN) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/prod_accum.sv
// Sums a group of up to ACC_LEN signed products and holds the result
// until downstream takes it.
//
//   state | meaning
//   IDLE  | no group open; the first accepted beat starts one
//   ACCUM | group open; beats are added until in_last or ACC_LEN
//   HOLD  | result presented on out_valid; inputs are stalled
module prod_accum #(
  parameter  int N       = booth_pkg::N,
  parameter  int ACC_LEN = booth_pkg::ACC_LEN,
  localparam int PW      = 2 * N,
  localparam int ACC_W   = PW + $clog2(ACC_LEN),
  localparam int CW      = $clog2(ACC_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    prod,
  input  logic             in_last,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CW-1:0]    out_count
);

  import booth_pkg::state_e;
  import booth_pkg::IDLE;
  import booth_pkg::ACCUM;
  import booth_pkg::HOLD;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]           count_q, count_d;
  logic signed [ACC_W-1:0] prod_ext;
  logic [CW-1:0]           count_inc;
  logic                    group_done;

  // Widen before adding so ACC_LEN worst-case products can never wrap.
  assign prod_ext   = {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign count_inc  = count_q + CW'(1);
  assign group_done = in_last || (count_inc == CW'(ACC_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          acc_d   = '0;
          count_d = '0;
        end else if (in_valid) begin
          acc_d   = prod_ext;
          count_d = CW'(1);
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (flush) begin
          acc_d   = '0;
          count_d = '0;
          state_d = IDLE;
        end else if (in_valid) begin
          acc_d   = acc_q + prod_ext;
          count_d = count_inc;
          if (group_done) state_d = HOLD;
        end
      end
      HOLD: begin
        // flush is deliberately ignored here: a finished result is never discarded.
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign acc_out   = acc_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_prod_accum.sv
// Directed and randomized checks of prod_accum against a group-level model
// that tracks the running sum as a plain integer.
module tb_prod_accum;
  import booth_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PW-1:0]    prod = '0;
  logic             in_last = 1'b0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] acc_out;
  logic [CW-1:0]    out_count;

  int n_cmp = 0;
  int n_err = 0;

  longint m_sum  = 0;
  int     m_cnt  = 0;
  bit     m_pend = 1'b0;

  prod_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .in_last   (in_last),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [ACC_W-1:0] exp_acc;
    logic [CW-1:0]    exp_cnt;
    exp_acc = m_sum[ACC_W-1:0];
    exp_cnt = m_cnt[CW-1:0];
    cmp({tag, ".out_valid"}, 64'(out_valid), 64'(m_pend));
    cmp({tag, ".in_ready"},  64'(in_ready),  64'(!m_pend));
    if (m_pend) begin
      cmp({tag, ".acc_out"},   64'(acc_out),   64'(exp_acc));
      cmp({tag, ".out_count"}, 64'(out_count), 64'(exp_cnt));
    end
  endtask

  // One clock: drive inputs, advance the model by the group rules, check.
  task automatic step(input bit v, input int p, input bit l, input bit f, input bit r,
                      input string tag);
    logic [31:0] pv;
    pv        = p;
    in_valid  = v;
    prod      = pv[PW-1:0];
    in_last   = l;
    flush     = f;
    out_ready = r;
    @(posedge clk);
    if (m_pend) begin
      if (r) begin
        m_pend = 1'b0;
        m_sum  = 0;
        m_cnt  = 0;
      end
    end else if (f) begin
      m_sum = 0;
      m_cnt = 0;
    end else if (v) begin
      m_sum += p;
      m_cnt++;
      if (l || m_cnt == ACC_LEN) m_pend = 1'b1;
    end
    #1;
    check_outputs(tag);
  endtask

  // Assert reset between clock edges and confirm the outputs clear without a clock.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    cmp({tag, ".out_valid"}, 64'(out_valid), 64'(0));
    cmp({tag, ".acc_out"},   64'(acc_out),   64'(0));
    cmp({tag, ".out_count"}, 64'(out_count), 64'(0));
    cmp({tag, ".in_ready"},  64'(in_ready),  64'(1));
    m_pend = 1'b0;
    m_sum  = 0;
    m_cnt  = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int rand_prod();
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel == 0) return -(1 << (PW-1));
    if (sel == 1) return (1 << (PW-1)) - 1;
    return int'($urandom_range(0, (1 << PW) - 1)) - (1 << (PW-1));
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cmp("reset.out_valid", 64'(out_valid), 64'(0));
    cmp("reset.in_ready",  64'(in_ready),  64'(1));
    cmp("reset.acc_out",   64'(acc_out),   64'(0));
    cmp("reset.out_count", 64'(out_count), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Eight beats 1..8 close the group on the length limit.
    for (int i = 1; i <= 8; i++) step(1, i, 0, 0, 1, "eight");
    cmp("eight.sum", 64'(acc_out), 64'(36));
    step(0, 0, 0, 0, 1, "eight_take");

    // -5 then 3 with in_last.
    step(1, -5, 0, 0, 1, "neg");
    step(1, 3, 1, 0, 1, "neg");
    cmp("neg.sum", 64'(acc_out), 64'(23'h7FFFFE));
    step(0, 0, 0, 0, 1, "neg_take");

    // Eight most-negative products reach -2^22 without wrapping.
    for (int i = 0; i < 8; i++) step(1, -(1 << 19), 0, 0, 0, "minneg");
    cmp("minneg.sum", 64'(acc_out), 64'(23'h400000));

    // Result held for 10 cycles while beats are offered, then taken.
    for (int i = 0; i < 10; i++) step(1, 77, i[0], 1, 0, "hold");
    step(1, 99, 0, 0, 1, "hold_take");
    step(0, 0, 0, 0, 1, "hold_idle");

    // Flush with a simultaneous beat discards everything.
    for (int i = 0; i < 3; i++) step(1, 100 + i, 0, 0, 1, "flush_pre");
    step(1, 500, 1, 1, 1, "flush");
    step(0, 0, 1, 0, 1, "last_no_valid");
    step(1, 4, 0, 0, 1, "after_flush");
    step(1, 6, 1, 0, 1, "after_flush");
    cmp("after_flush.sum", 64'(acc_out), 64'(10));
    cmp("after_flush.cnt", 64'(out_count), 64'(2));
    step(0, 0, 0, 0, 1, "after_flush_take");

    // Reset mid-ACCUM, then a fresh group sums from zero.
    step(1, 1000, 0, 0, 1, "rst_accum");
    step(1, 2000, 0, 0, 1, "rst_accum");
    async_reset("rst_accum");
    step(1, 7, 0, 0, 0, "post_rst1");
    step(1, 8, 1, 0, 0, "post_rst1");
    cmp("post_rst1.sum", 64'(acc_out), 64'(15));

    // Reset mid-HOLD drops the pending result without a handshake.
    async_reset("rst_hold");
    step(1, -3, 1, 0, 0, "post_rst2");
    cmp("post_rst2.sum", 64'(acc_out), 64'(23'h7FFFFD));
    step(0, 0, 0, 0, 1, "post_rst2_take");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7,
           rand_prod(),
           $urandom_range(0, 9) < 2,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 6,
           "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter N, default 10: operand width of the upstream Booth multiplier.
REQ-002 Parameter ACC_LEN, default 8: maximum products per accumulation (power of two, >=2).
REQ-003 Derived constants, fixed in the package: PW = 2*N, ACC_W = PW + clog2(ACC_LEN), CW = clog2(ACC_LEN)+1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream product valid.
REQ-007 in_ready  output  1  block can accept a product this cycle.
REQ-008 prod  input  PW  signed two's-complement product from the multiplier.
REQ-009 in_last  input  1  qualifies the accepted beat as the final one of the group.
REQ-010 flush  input  1  synchronous abort of the current group.
REQ-011 out_valid  output  1  accumulated result is valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 acc_out  output  ACC_W  signed sum of the group.
REQ-014 out_count  output  CW  number of products in the group, 1..ACC_LEN.

Function
REQ-015 A beat is accepted when in_valid && in_ready at a rising edge; a result is taken when out_valid && out_ready.
REQ-016 The FSM has states IDLE, ACCUM and HOLD; in_ready = 1 in IDLE and ACCUM and 0 in HOLD.
REQ-017 An accepted beat in IDLE loads acc = sign-extended prod and count = 1, then moves to ACCUM.
REQ-018 An accepted beat in ACCUM sets acc = acc + sign-extended prod and count = count + 1.
REQ-019 An accepted beat that has in_last=1 or makes count equal ACC_LEN moves to HOLD, including the first beat from IDLE.
REQ-020 out_valid = 1 exactly in HOLD: one cycle of latency from the final accepted beat.
REQ-021 acc_out and out_count are stable throughout HOLD.
REQ-022 A result handshake in HOLD moves to IDLE, and out_valid drops on the next cycle.
REQ-023 No beat is accepted in the handshake cycle itself.
REQ-024 With out_ready=0, HOLD persists indefinitely.
REQ-025 Summation is full-width and never overflows, since ACC_W covers ACC_LEN worst-case products, including (-2^(PW-1)) x ACC_LEN.
REQ-026 flush=1 in IDLE or ACCUM forces IDLE and zeroes acc and count, discarding any simultaneously offered beat.
REQ-027 flush is ignored in HOLD.
REQ-028 in_last presented without in_valid, or in a cycle where the beat is not accepted, has no effect.
REQ-029 No bubble is required between groups: in IDLE a new group starts on the first accepted beat.

Reset
REQ-030 rst_n low asynchronously forces state IDLE, acc = 0, count = 0, out_valid = 0 and in_ready = 1 (after release).
REQ-031 Reset during ACCUM or HOLD discards the partial or pending result with no output handshake.
REQ-032 Reset deassertion takes effect at the first rising edge; no beat is accepted while rst_n is low.

Structure
REQ-033 Package booth_pkg holds N, ACC_LEN, PW, ACC_W and CW and the FSM state enum type, shared with the multiplier stage.
REQ-034 The block is a single module with no sub-modules; the adder is inferred with behavioural "+" on ACC_W-bit signed operands.
REQ-035 acc_out and out_count come directly from registers, with no combinational path from the inputs.

Verification
REQ-036 Eight beats prod = 1..8 with in_last=0 and out_ready=1 -> out_valid one cycle after beat 8, acc_out = 36, out_count = 8.
REQ-037 Beats -5, 3, with in_last on the second -> acc_out = -2 (0x7FFFFE at ACC_W=23), out_count = 2.
REQ-038 Eight beats of -2^19 -> acc_out = -2^22, with no wrap.
REQ-039 Result pending with out_ready low for 10 cycles -> in_ready = 0, acc_out stable, and offered beats are not accepted; then out_ready=1 -> IDLE the next cycle.
REQ-040 Three beats, then flush together with in_valid -> no output; the next group of 4 then 6 with in_last -> acc_out = 10, out_count = 2.
REQ-041 rst_n pulsed low mid-ACCUM and mid-HOLD, asynchronously to clk -> out_valid drops immediately and the next group sums from 0.
